mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_LS_STREAK, default 4: the maximum number of consecutive load/store grants while a fetch is waiting.
REQ-002 SHALL have the following ports. The clock and reset are one clock `clk` and asynchronous active-high `reset`.
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  asynchronous, active-high.
  - if_req_i  in  1  instruction-fetch request, level.
  - if_addr_i  in  32  fetch address.
  - ls_req_i  in  1  load/store request, level.
  - ls_we_i  in  1  1 = store, 0 = load.
  - ls_addr_i  in  32  load/store address.
  - ls_wdata_i  in  32  store data.
  - mem_ready_i  in  1  memory completes the current access this cycle.
  - mem_rdata_i  in  32  memory read data, valid with mem_ready_i.
  - mem_req_o  out  1  access in flight.
  - mem_we_o  out  1  write strobe.
  - mem_addr_o  out  32  memory address.
  - mem_wdata_o  out  32  write data.
  - select_o  out  1  address-mux select: 0 = fetch (I0), 1 = load/store (I1).
  - if_gnt_o  out  1  fetch request accepted this cycle.
  - ls_gnt_o  out  1  load/store request accepted this cycle.
  - if_done_o  out  1  fetch complete, one-cycle pulse.
  - ls_done_o  out  1  load/store complete, one-cycle pulse.
  - rdata_o  out  32  read data, valid with the done pulses.

Function
REQ-003 SHALL implement an FSM with states IDLE, BUSY_IF and BUSY_LS.
REQ-004 In IDLE, SHALL grant at most one requester per cycle. if_gnt_o and ls_gnt_o are combinational from the state and the request inputs, and are never both high.
REQ-005 Arbitration SHALL use fixed priority, load/store over fetch, with one exception: if if_req_i=1 and streak == MAX_LS_STREAK, fetch wins.
REQ-006 The streak counter SHALL update as follows.
  - Increments on each ls grant made while if_req_i=1.
  - Clears on any fetch grant, or on an ls grant with if_req_i=0.
  - Saturates at MAX_LS_STREAK.
REQ-007 On a grant, SHALL do all of the following at the same clock edge, then go to BUSY_IF or BUSY_LS.
  - Latch the address into mem_addr_o.
  - For ls: latch the write strobe and data into mem_we_o and mem_wdata_o.
  - For fetch: set mem_we_o=0.
  - Set select_o.
REQ-008 In BUSY_x, mem_req_o SHALL be 1, and the address, write strobe, write data and select_o SHALL be held stable.
REQ-009 Requester inputs SHALL be ignored outside IDLE.
REQ-010 When mem_ready_i=1 in BUSY_x, at that clock edge SHALL:
  - capture mem_rdata_i into rdata_o (stores capture as well; requesters ignore the value);
  - assert x_done_o for exactly the next cycle;
  - return to IDLE.
REQ-011 mem_ready_i SHALL be ignored in IDLE.
REQ-012 A requester that is still asserting in the cycle its done pulse is high SHALL be eligible for a grant in that same IDLE cycle, giving back-to-back accesses.
REQ-013 Latency SHALL be:
  - grant at cycle N;
  - mem_req_o high from cycle N+1;
  - with ready at cycle N+1+W (W wait states), done at cycle N+2+W.
  - Minimum request-to-done latency is 2 cycles.
REQ-014 A requester SHALL deassert or change its request after its grant. A request held high is treated as a new request in the next IDLE cycle.
REQ-015 select_o SHALL keep its last value while in IDLE.
REQ-016 There SHALL be no timeout; BUSY_x persists until mem_ready_i=1.

Reset
REQ-017 When reset is asserted, SHALL asynchronously do all of the following:
  - FSM to IDLE, streak to 0;
  - mem_req_o, mem_we_o, select_o, both done outputs and both gnt outputs to 0;
  - mem_addr_o, mem_wdata_o and rdata_o to 32'h0.
REQ-018 A reset during BUSY_x SHALL abort the access with no done pulse. The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-019 Fetch only.
  - Stimulus: if_req_i=1, if_addr_i=32'h0000_0100, mem_ready_i=1 with mem_rdata_i=32'h0010_0093 one cycle after the grant.
  - Response: if_gnt_o at cycle 0; mem_req_o=1 and select_o=0 at cycle 1; if_done_o=1 and rdata_o=32'h0010_0093 at cycle 2.
REQ-020 Simultaneous requests.
  - Stimulus: if_req_i=1 and ls_req_i=1 with ls_we_i=1, ls_addr_i=32'h0000_2000, ls_wdata_i=32'hDEAD_BEEF.
  - Response: ls_gnt_o only; mem_we_o=1, mem_addr_o=32'h0000_2000, mem_wdata_o=32'hDEAD_BEEF, select_o=1.
REQ-021 Starvation guard.
  - Stimulus: both requests held high with mem_ready_i=1 constantly, MAX_LS_STREAK=4.
  - Response: grant sequence LS, LS, LS, LS, IF, LS, ...
REQ-022 Wait states.
  - Stimulus: mem_ready_i held 0 for 5 cycles during BUSY_LS, with ls_req_i toggling.
  - Response: mem_req_o and mem_addr_o stable; no new grant; exactly one ls_done_o after ready.
REQ-023 Reset mid-access.
  - Stimulus: reset pulsed during BUSY_IF.
  - Response: mem_req_o=0 immediately, no if_done_o, all outputs 0; the next if_req_i is granted in the first cycle after reset.
REQ-024 Back-to-back.
  - Stimulus: ls_req_i held high, mem_ready_i=1.
  - Response: a grant every 2 cycles; ls_gnt_o coincides with the previous ls_done_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store.
// Load/store has priority unless fetch has waited MAX_LS_STREAK grants.
module mem_port_arbiter #(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        select_o,
    output logic        if_gnt_o,
    output logic        ls_gnt_o,
    output logic        if_done_o,
    output logic        ls_done_o,
    output logic [31:0] rdata_o
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          fetch_starved;
    logic          ls_win;
    logic          if_win;

    // Grants are decided combinationally so a requester still asserting during
    // its done cycle can be re-granted without a bubble.
    always_comb begin
        fetch_starved = if_req_i && (streak == STREAK_MAX);
        ls_win        = !reset && (state == IDLE) && ls_req_i && !fetch_starved;
        if_win        = !reset && (state == IDLE) && if_req_i && !ls_win;
        ls_gnt_o      = ls_win;
        if_gnt_o      = if_win;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            streak      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            select_o    <= 1'b0;
            if_done_o   <= 1'b0;
            ls_done_o   <= 1'b0;
            rdata_o     <= 32'h0;
        end else begin
            if_done_o <= 1'b0;
            ls_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_win) begin
                        state       <= BUSY_LS;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_we_i;
                        mem_addr_o  <= ls_addr_i;
                        mem_wdata_o <= ls_wdata_i;
                        select_o    <= 1'b1;
                        // Only a waiting fetch makes a load/store grant count.
                        if (!if_req_i) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (if_win) begin
                        state      <= BUSY_IF;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        select_o   <= 1'b0;
                        streak     <= '0;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    if (mem_ready_i) begin
                        rdata_o   <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        if_done_o <= (state == BUSY_IF);
                        ls_done_o <= (state == BUSY_LS);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction model.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_i, ls_req_i, ls_we_i, mem_ready_i;
    logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
    logic        mem_req_o, mem_we_o, select_o;
    logic        if_gnt_o, ls_gnt_o, if_done_o, ls_done_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;

    mem_port_arbiter #(.MAX_LS_STREAK(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .select_o(select_o),
        .if_gnt_o(if_gnt_o), .ls_gnt_o(ls_gnt_o),
        .if_done_o(if_done_o), .ls_done_o(ls_done_o), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: one outstanding access described as a record.
    bit          m_pending;
    bit          m_pending_is_ls;
    bit          m_req, m_we, m_sel, m_if_done, m_ls_done;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_streak;
    bit          exp_ls_gnt, exp_if_gnt;

    bit          record_grants = 0;
    int          grant_log[$];
    int          ls_done_seen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lsr,
                                 input logic we, input logic [31:0] lsa, input logic [31:0] wd,
                                 input logic rdy, input logic [31:0] rd);
        if_req_i    = ifr;
        if_addr_i   = ifa;
        ls_req_i    = lsr;
        ls_we_i     = we;
        ls_addr_i   = lsa;
        ls_wdata_i  = wd;
        mem_ready_i = rdy;
        mem_rdata_i = rd;
    endtask

    task automatic modelReset();
        m_pending = 0; m_pending_is_ls = 0;
        m_req = 0; m_we = 0; m_sel = 0; m_if_done = 0; m_ls_done = 0;
        m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
        m_streak = 0;
    endtask

    task automatic checkAll();
        exp_ls_gnt = !reset && !m_pending && ls_req_i && !(if_req_i && m_streak == MAX);
        exp_if_gnt = !reset && !m_pending && if_req_i && !exp_ls_gnt;
        checkOutput("ls_gnt", ls_gnt_o, exp_ls_gnt);
        checkOutput("if_gnt", if_gnt_o, exp_if_gnt);
        checkOutput("mem_req", mem_req_o, m_req);
        checkOutput("mem_we", mem_we_o, m_we);
        checkOutput("mem_addr", mem_addr_o, m_addr);
        checkOutput("mem_wdata", mem_wdata_o, m_wdata);
        checkOutput("select", select_o, m_sel);
        checkOutput("if_done", if_done_o, m_if_done);
        checkOutput("ls_done", ls_done_o, m_ls_done);
        checkOutput("rdata", rdata_o, m_rdata);
        if (ls_done_o) ls_done_seen++;
        if (record_grants) begin
            if (ls_gnt_o) grant_log.push_back(2);
            else if (if_gnt_o) grant_log.push_back(1);
        end
    endtask

    task automatic modelStep();
        m_if_done = 0;
        m_ls_done = 0;
        if (m_pending) begin
            if (mem_ready_i) begin
                m_rdata   = mem_rdata_i;
                m_ls_done = m_pending_is_ls;
                m_if_done = !m_pending_is_ls;
                m_pending = 0;
                m_req     = 0;
            end
        end else if (exp_ls_gnt) begin
            m_pending = 1; m_pending_is_ls = 1; m_req = 1;
            m_addr = ls_addr_i; m_we = ls_we_i; m_wdata = ls_wdata_i; m_sel = 1;
            m_streak = if_req_i ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
        end else if (exp_if_gnt) begin
            m_pending = 1; m_pending_is_ls = 0; m_req = 1;
            m_addr = if_addr_i; m_we = 0; m_sel = 0;
            m_streak = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Called just after a rising edge; the first grant can happen in the following cycle.
    task automatic doReset();
        reset = 1'b1;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int exp_kind;
        reset = 1'b1;
        applyStimulus(1, 32'h10, 1, 1, 32'h20, 32'h30, 1, 32'h40);
        modelReset();
        #2;
        checkAll();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch only: grant, then ready one cycle later.
        applyStimulus(1, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        cycle();
        checkOutput("fetch_req", mem_req_o, 1);
        checkOutput("fetch_sel", select_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0010_0093);
        cycle();
        checkOutput("fetch_done", if_done_o, 1);
        checkOutput("fetch_rdata", rdata_o, 32'h0010_0093);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Simultaneous requests: load/store wins.
        applyStimulus(1, 32'h0000_0200, 1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 0, 0);
        cycle();
        checkOutput("simul_we", mem_we_o, 1);
        checkOutput("simul_addr", mem_addr_o, 32'h0000_2000);
        checkOutput("simul_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        checkOutput("simul_sel", select_o, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        cycle();
        cycle();

        // Starvation guard.
        doReset();
        grant_log.delete();
        record_grants = 1;
        applyStimulus(1, 32'h0000_0400, 1, 0, 32'h0000_3000, 0, 1, 32'hAAAA_5555);
        for (int i = 0; i < 20; i++) cycle();
        record_grants = 0;
        checkOutput("starve_count", grant_log.size(), 10);
        for (int i = 0; i < grant_log.size() && i < 10; i++) begin
            exp_kind = (i % 5 == 4) ? 1 : 2;
            checkOutput($sformatf("starve_seq%0d", i), grant_log[i], exp_kind);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();

        // Wait states with a toggling load/store request.
        ls_done_seen = 0;
        applyStimulus(0, 0, 1, 0, 32'h0000_5000, 32'h1, 0, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h0000_0800, i[0], 1, 32'h0000_6000 + i, 32'h2, 0, 0);
            cycle();
            checkOutput("wait_req", mem_req_o, 1);
            checkOutput("wait_addr", mem_addr_o, 32'h0000_5000);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) cycle();
        checkOutput("wait_done_count", ls_done_seen, 1);

        // Reset in the middle of a fetch.
        applyStimulus(1, 32'h0000_0900, 0, 0, 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_req", mem_req_o, 0);
        checkOutput("rst_mid_addr", mem_addr_o, 0);
        modelReset();
        @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;
        applyStimulus(1, 32'h0000_0A00, 0, 0, 0, 0, 1, 32'h6);
        #1;
        checkOutput("rst_first_gnt", if_gnt_o, 1);
        checkOutput("rst_no_done", if_done_o, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6);
        cycle();

        // Back-to-back load/store.
        applyStimulus(0, 0, 1, 0, 32'h0000_7000, 0, 1, 32'h0BAD_F00D);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i % 2 == 1) checkOutput("b2b_done", ls_done_o, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) doReset();
            applyStimulus($urandom() % 2 == 1, $urandom(), $urandom() % 2 == 1,
                          $urandom() % 2 == 1, $urandom(), $urandom(),
                          $urandom() % 4 != 0, $urandom());
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
